// File: rtl/seq_detect_pkg.sv
// Shared state encodings and the q pattern helper for the sequence detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ARMED  = ST_ARMED;
    localparam logic [1:0] S_LOCKED = ST_LOCKED;
    localparam logic [1:0] S_FAULT  = ST_FAULT;

    // Two-bit repeating unit; the top replicates it to the full output width.
    function automatic logic [1:0] state_unit(input logic [1:0] st);
        case (st)
            S_ARMED:  return 2'b01;
            S_LOCKED: return 2'b11;
            S_FAULT:  return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/seq_detect_fsm_sync_pipe.sv
// Input synchroniser with a valid bit travelling alongside the data.
module sync_pipe #(
    parameter int DW     = 4,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] d,
    output logic          d_vld
);

    logic [STAGES-1:0][DW-1:0] data_pipe;
    logic [STAGES-1:0]         vld_pipe;

    always_ff @(posedge clk) begin
        if (srst) begin
            data_pipe <= '0;
            vld_pipe  <= '0;
        end else begin
            data_pipe <= {data_pipe[STAGES-2:0], din};
            vld_pipe  <= {vld_pipe[STAGES-2:0], 1'b1};
        end
    end

    assign d     = data_pipe[STAGES-1];
    assign d_vld = vld_pipe[STAGES-1];

endmodule

// File: rtl/seq_detect_fsm.sv
// Command-code sequence detector: IDLE/ARMED/LOCKED/FAULT with an ARMED timeout.
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int OUT_W       = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [DW-1:0]    din,
    input  logic [DW-1:0]    code_arm,
    input  logic [DW-1:0]    code_lock,
    input  logic [DW-1:0]    code_rearm,
    input  logic [DW-1:0]    code_abort,
    output logic [OUT_W-1:0] q,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] lock_cnt,
    output logic             fault_pulse
);

    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [DW-1:0] d;
    logic          d_vld;
    logic [1:0]    state, state_nxt;
    logic [TW-1:0] timer;
    logic          hit_arm, hit_lock, hit_rearm, hit_abort, expired;

    sync_pipe #(.DW(DW), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .srst  (srst),
        .din   (din),
        .d     (d),
        .d_vld (d_vld)
    );

    assign hit_arm   = d_vld && (d == code_arm);
    assign hit_lock  = d_vld && (d == code_lock);
    assign hit_rearm = d_vld && (d == code_rearm);
    assign hit_abort = d_vld && (d == code_abort);
    // timer counts staying edges, so the TIMEOUT-th ARMED cycle sees TIMEOUT-1
    assign expired   = (timer == TMR_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!hit_abort && hit_arm) state_nxt = S_ARMED;
            S_ARMED: begin
                if (hit_abort)     state_nxt = S_IDLE;
                else if (hit_lock) state_nxt = S_LOCKED;
                else if (expired)  state_nxt = S_FAULT;
            end
            S_LOCKED: begin
                if (hit_abort)      state_nxt = S_IDLE;
                else if (hit_rearm) state_nxt = S_ARMED;
            end
            S_FAULT:  if (hit_abort) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= S_IDLE;
            timer       <= '0;
            lock_cnt    <= '0;
            fault_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            fault_pulse <= (state_nxt == S_FAULT) && (state != S_FAULT);
            if (state_nxt == S_ARMED && state != S_ARMED)
                timer <= '0;
            else if (state == S_ARMED && timer != TMR_LAST)
                timer <= timer + 1'b1;
            if (state == S_ARMED && state_nxt == S_LOCKED && lock_cnt != CNT_MAX)
                lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign state_o = state;
    assign q       = {(OUT_W/2){state_unit(state)}};

endmodule

// File: doc/seq_detect_fsm.md
SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 SHALL have parameter DW, default 4: data/code width, range 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..4.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum consecutive ARMED cycles, range 2..65535.
REQ-004 SHALL have parameter OUT_W, default 8: pattern output width, even, range 2..32.
REQ-005 SHALL have parameter CNT_W, default 8: lock counter width.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port srst, input, 1: reset, synchronous, active-high, applied directly without synchronisation.
REQ-008 SHALL have port din, input, DW: asynchronous command code.
REQ-009 SHALL have ports code_arm, code_lock, code_rearm and code_abort, each input, DW: quasi-static codes, changed only while srst=1.
REQ-010 SHALL have port q, output, OUT_W: state pattern.
REQ-011 SHALL have port state_o, output, 2: current state encoding.
REQ-012 SHALL have port lock_cnt, output, CNT_W: number of entries into LOCKED.
REQ-013 SHALL have port fault_pulse, output, 1: one-cycle pulse on entry into FAULT.

Function
REQ-014 SHALL pass din through a SYNC_STAGES flop chain; the FSM compares only the last stage (d).
REQ-015 Each chain stage SHALL carry a valid bit, cleared by srst. FSM comparisons SHALL be disabled until the valid bit reaches the last stage, i.e. for SYNC_STAGES cycles after srst deasserts.
REQ-016 A din value sampled at edge n SHALL determine the state update at edge n+SYNC_STAGES.
REQ-017 States SHALL be IDLE=0, ARMED=1, LOCKED=2, FAULT=3.
REQ-018 IDLE: d==code_arm SHALL go to ARMED; otherwise IDLE SHALL hold.
REQ-019 ARMED: d==code_abort SHALL go to IDLE; else d==code_lock SHALL go to LOCKED; else timer expiry SHALL go to FAULT; otherwise ARMED SHALL hold.
REQ-020 LOCKED: d==code_abort SHALL go to IDLE; else d==code_rearm SHALL go to ARMED; otherwise LOCKED SHALL hold.
REQ-021 FAULT: only d==code_abort SHALL exit, to IDLE.
REQ-022 Priority when codes are equal SHALL be abort > lock/rearm > arm > timeout; a matching code SHALL override timer expiry in the same cycle.
REQ-023 The timer SHALL clear on every entry to ARMED (including from LOCKED) and increment each cycle in ARMED.
REQ-024 Expiry SHALL occur when ARMED has been held TIMEOUT consecutive cycles; the next edge enters FAULT.
REQ-025 The timer width SHALL be clog2(TIMEOUT+1), with no wrap.
REQ-026 q SHALL be a combinational decode of the state: IDLE all-0, ARMED 0101.. (0x55 for 8 bits), LOCKED all-1, FAULT 1010.. (0xAA).
REQ-027 lock_cnt SHALL increment on each ARMED->LOCKED edge and saturate at 2^CNT_W-1.
REQ-028 fault_pulse SHALL be registered and high for exactly the first cycle state_o==FAULT.

Reset
REQ-029 While srst=1 at an edge: state=IDLE, q=0, state_o=0, lock_cnt=0, fault_pulse=0, timer=0, and all sync data and valid bits=0.
REQ-030 srst asserted mid-operation in any state, including FAULT or ARMED near expiry, SHALL take priority over every transition.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the state enum, the state_o encodings and the pattern-generation function for q.
REQ-032 Sub-module sync_pipe (parameters DW and STAGES, with a valid bit) SHALL implement REQ-014 and REQ-015; the FSM, timer and counter SHALL live in seq_detect_fsm.

Verification
Bench parameters: DW=4, SYNC_STAGES=2, TIMEOUT=8, arm=1, lock=2, rearm=4, abort=8.
REQ-033 Basic lock: din=1 then 2 -> state_o 0->1->2, q 0x00->0x55->0xFF, each change 2 cycles after the din edge; lock_cnt=1.
REQ-034 Timeout: din=1 then held at 0 -> FAULT entered 8 cycles after ARMED entry, q=0xAA, fault_pulse high exactly 1 cycle; din=8 -> IDLE.
REQ-035 Race: din=2 arrives in the same cycle as expiry -> LOCKED, not FAULT.
REQ-036 Rearm loop: lock, din=4, wait 7 cycles, din=2, repeated 300 times -> lock_cnt saturates at 255; no FAULT.
REQ-037 Reset blanking: code_arm=0, din=0, pulse srst -> state stays IDLE for 2 cycles after release, then ARMED.
REQ-038 Mid-operation reset: srst asserted in LOCKED with lock_cnt=5 -> next edge all outputs 0; old sync contents do not cause a transition.
